// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate execution unit.
//   - op encoding constants (OP_SHR .. OP_ROL); codes above OP_ROL are illegal
//   - control state enum
//   - helpers for the derived amount width and op legality
package shift_pkg;

    localparam logic [2:0] OP_SHR  = 3'd0;
    localparam logic [2:0] OP_SHRA = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_ROR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of the effective shift amount for a power-of-two word width.
    function automatic int amt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    function automatic logic op_illegal(input logic [2:0] op);
        return (op > OP_ROL);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter/rotator.
// Ports:
//   op        in  3       operation code (shift_pkg encoding); illegal codes pass data through
//   data      in  WIDTH   current accumulator value
//   step      in  STEP_W  positions to move this step (never reaches WIDTH)
//   next_data out WIDTH   data after one step
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STEP_W = 6
) (
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  data,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  next_data
);

    logic [WIDTH-1:0] rot_r;
    logic [WIDTH-1:0] rot_l;

    // A shift by WIDTH yields zero, so step==0 degrades cleanly to data.
    always_comb begin
        rot_r = (data >> step) | (data << (WIDTH - int'(step)));
        rot_l = (data << step) | (data >> (WIDTH - int'(step)));
    end

    always_comb begin
        next_data = data;
        case (op)
            OP_SHR:  next_data = data >> step;
            OP_SHRA: next_data = $signed(data) >>> step;
            OP_SHL:  next_data = data << step;
            OP_ROR:  next_data = rot_r;
            OP_ROL:  next_data = rot_l;
            default: next_data = data;
        endcase
    end

endmodule

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate execution unit (SHR, SHRA, SHL, ROR, ROL).
// Moves at most MAX_STEP positions per clock; start/ready/done handshake.
// Ports:
//   clock      in  1      system clock, rising edge
//   clear      in  1      synchronous active-low reset
//   start      in  1      request, accepted only while ready
//   op         in  3      operation code (5..7 illegal)
//   a          in  WIDTH  value to shift/rotate
//   b          in  WIDTH  amount source, low AMT_W bits used (amount mod WIDTH)
//   ready      out 1      start can be accepted this cycle
//   busy       out 1      shifting in progress
//   done       out 1      one-cycle pulse, result valid
//   result     out WIDTH  registered result, held until next completion
//   illegal_op out 1      qualifies done; op was illegal
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | moving acc by min(rem, MAX_STEP) each cycle
// DONE  | result valid for one cycle; may accept a new start
module shift_rotate_unit
    import shift_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_STEP = 8,
    parameter int AMT_W    = amt_width(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             illegal_op
);

    // One extra bit so MAX_STEP == WIDTH is representable.
    localparam int CW = AMT_W + 1;
    localparam logic [CW-1:0] MAX_STEP_C = CW'(MAX_STEP);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] acc;
    logic [AMT_W-1:0] rem;
    logic [2:0]       op_q;

    logic             accept;
    logic             op_bad;
    logic             direct;
    logic [CW-1:0]    rem_ext;
    logic [CW-1:0]    step_amt;
    logic             last_step;
    logic [WIDTH-1:0] step_out;
    logic             unused_b;

    assign unused_b  = ^b[WIDTH-1:AMT_W];

    assign accept    = start && ready;
    assign op_bad    = op_illegal(op);
    // Zero amount or illegal op skip SHIFT and complete immediately.
    assign direct    = (b[AMT_W-1:0] == '0) || op_bad;
    assign rem_ext   = {1'b0, rem};
    assign last_step = (rem_ext <= MAX_STEP_C);
    assign step_amt  = last_step ? rem_ext : MAX_STEP_C;

    shift_step #(
        .WIDTH  (WIDTH),
        .STEP_W (CW)
    ) u_step (
        .op        (op_q),
        .data      (acc),
        .step      (step_amt),
        .next_data (step_out)
    );

    always_ff @(posedge clock) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    next_state = direct ? DONE : SHIFT;
                end else begin
                    next_state = IDLE;
                end
            end
            SHIFT:   next_state = last_step ? DONE : SHIFT;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE) || (state == DONE);
        busy  = (state == SHIFT);
        done  = (state == DONE);
    end

    // result/illegal_op update only on entry to DONE.
    always_ff @(posedge clock) begin
        if (!clear) begin
            acc        <= '0;
            rem        <= '0;
            op_q       <= OP_SHR;
            result     <= '0;
            illegal_op <= 1'b0;
        end else if (accept) begin
            acc  <= a;
            rem  <= b[AMT_W-1:0];
            op_q <= op;
            if (direct) begin
                result     <= a;
                illegal_op <= op_bad;
            end
        end else if (state == SHIFT) begin
            acc <= step_out;
            rem <= rem - step_amt[AMT_W-1:0];
            if (last_step) begin
                result     <= step_out;
                illegal_op <= 1'b0;
            end
        end
    end

endmodule
